// File: rtl/jt900h_bus_pkg.sv
// Shared definitions for the jt900h memory access unit.
//
// Contents:
//   - access size codes (BYTE_SZ/WORD_SZ/LONG_SZ; code 3 also means long)
//   - address source selects (PC_ASEL/EA_ASEL/XSP_ASEL/DA_ASEL)
//   - bus sequencer state encoding (BUS_IDLE/BUS_CYC/BUS_END)
//   - helpers for byte count and 16-bit lane selection
package jt900h_bus_pkg;

    // Access size codes as issued by the control unit
    localparam logic [1:0] BYTE_SZ = 2'd0;
    localparam logic [1:0] WORD_SZ = 2'd1;
    localparam logic [1:0] LONG_SZ = 2'd2;

    // Address source selects
    localparam logic [1:0] PC_ASEL  = 2'd0;
    localparam logic [1:0] EA_ASEL  = 2'd1;
    localparam logic [1:0] XSP_ASEL = 2'd2;
    localparam logic [1:0] DA_ASEL  = 2'd3;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_CYC  = 2'd1,
        BUS_END  = 2'd2
    } bus_state_e;

    // Number of bytes moved by a request; size code 3 aliases long
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        logic [2:0] n;
        case (sz)
            BYTE_SZ: n = 3'd1;
            WORD_SZ: n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // Lanes used by the current bus cycle: [0]=even byte, [1]=odd byte.
    // An odd address can only reach the odd lane; an even address takes
    // both lanes when at least two bytes remain.
    function automatic logic [1:0] lane_mask(input logic a0, input logic [2:0] n);
        logic [1:0] m;
        if (a0) begin
            m = 2'b10;
        end else if (n >= 3'd2) begin
            m = 2'b11;
        end else begin
            m = 2'b01;
        end
        return m;
    endfunction

endpackage

// File: rtl/jt900h_bus.sv
// jt900h_bus: memory access unit feeding the register file.
//
// Accepts byte/word/long read or write requests addressed from PC, EA, XSP or
// DA and splits them into 16-bit little-endian bus cycles, handling odd
// alignment. Read bytes are assembled into din (zero-extended); busy stays
// high until the final bus cycle is acknowledged.
//
// Optional feature: define JT900H_BUS_TIMEOUT_EN to add a bus timeout of TOUT
// cen cycles per bus cycle; on expiry the access ends and buserr is set
// (sticky until reset). Without it buserr is tied low and CYC waits forever.
//
// Ports:
//   rst, clk, cen        asynchronous active-high reset, clock, clock enable
//   rd, wr, sz, addr_sel request strobes, size code, address source
//   pc, ea, xsp, da      candidate addresses (xsp uses bits [23:0])
//   wdata                write data, byte 0 at [7:0]
//   din                  assembled read data
//   busy                 access in progress
//   buserr               sticky timeout flag
//   bus_addr/bus_dout/bus_din/bus_cs/bus_we/bus_ok  external 16-bit bus
module jt900h_bus
    import jt900h_bus_pkg::*;
`ifdef JT900H_BUS_TIMEOUT_EN
#(
    parameter int unsigned TOUT = 15
)
`endif
(
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,

    input  logic        rd,
    input  logic        wr,
    input  logic [1:0]  sz,
    input  logic [1:0]  addr_sel,
    input  logic [23:0] pc,
    input  logic [23:0] ea,
    input  logic [31:0] xsp,
    input  logic [23:0] da,
    input  logic [31:0] wdata,

    output logic [31:0] din,
    output logic        busy,
    output logic        buserr,

    output logic [22:0] bus_addr,
    output logic [15:0] bus_dout,
    input  logic [15:0] bus_din,
    output logic        bus_cs,
    output logic [1:0]  bus_we,
    input  logic        bus_ok
);

    bus_state_e  state_q, state_d;
    logic [23:0] a_q, a_d;          // byte address of the next bus cycle
    logic [2:0]  n_q, n_d;          // bytes still to move
    logic [1:0]  k_q, k_d;          // index of the next byte within the request
    logic        wr_q, wr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] din_q, din_d;

    logic [23:0] a_sel;
    logic [1:0]  lane;
    logic [2:0]  step;
    logic [7:0]  wb0, wb1;
    logic        in_cyc;

    // Only the low 24 bits of the stack pointer form an address
    logic        unused_xsp;
    assign unused_xsp = ^xsp[31:24];

`ifdef JT900H_BUS_TIMEOUT_EN
    localparam int unsigned ToutW = $clog2(TOUT + 1);
    logic [ToutW-1:0] tcnt_q, tcnt_d;
    logic             buserr_q, buserr_d;
`endif

    always_comb begin
        case (addr_sel)
            PC_ASEL:  a_sel = pc;
            EA_ASEL:  a_sel = ea;
            XSP_ASEL: a_sel = xsp[23:0];
            default:  a_sel = da;
        endcase
    end

    assign in_cyc = (state_q == BUS_CYC);
    assign lane   = lane_mask(a_q[0], n_q);
    assign step   = (lane == 2'b11) ? 3'd2 : 3'd1;

    // Write bytes for the current cycle; wb1 is only meaningful on two-lane cycles
    assign wb0 = wdata_q[{k_q, 3'b000} +: 8];
    assign wb1 = wdata_q[{k_q + 2'd1, 3'b000} +: 8];

    always_comb begin
        bus_dout = 16'h0000;
        case (lane)
            2'b10:   bus_dout = {wb0, 8'h00};
            2'b01:   bus_dout = {8'h00, wb0};
            default: bus_dout = {wb1, wb0};
        endcase
    end

    assign bus_cs   = in_cyc;
    assign bus_we   = (in_cyc && wr_q) ? lane : 2'b00;
    assign bus_addr = a_q[23:1];
    assign busy     = in_cyc;
    assign din      = din_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        n_d     = n_q;
        k_d     = k_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        din_d   = din_q;
`ifdef JT900H_BUS_TIMEOUT_EN
        tcnt_d   = tcnt_q;
        buserr_d = buserr_q;
`endif

        if (cen) begin
            case (state_q)
                BUS_IDLE: begin
                    if (rd || wr) begin
                        state_d = BUS_CYC;
                        a_d     = a_sel;
                        n_d     = size_bytes(sz);
                        k_d     = 2'd0;
                        wr_d    = wr;          // write wins over read
                        wdata_d = wdata;
                        if (!wr) begin
                            din_d = 32'h0000_0000;
                        end
`ifdef JT900H_BUS_TIMEOUT_EN
                        tcnt_d = '0;
`endif
                    end
                end

                BUS_CYC: begin
                    if (bus_ok) begin
                        if (!wr_q) begin
                            case (lane)
                                2'b10: din_d[{k_q, 3'b000} +: 8] = bus_din[15:8];
                                2'b01: din_d[{k_q, 3'b000} +: 8] = bus_din[7:0];
                                default: begin
                                    din_d[{k_q, 3'b000} +: 8]        = bus_din[7:0];
                                    din_d[{k_q + 2'd1, 3'b000} +: 8] = bus_din[15:8];
                                end
                            endcase
                        end
                        // 24-bit add wraps at the top of the address space
                        a_d = a_q + {21'd0, step};
                        n_d = n_q - step;
                        k_d = k_q + step[1:0];
                        if (n_q == step) begin
                            state_d = BUS_END;
                        end
`ifdef JT900H_BUS_TIMEOUT_EN
                        tcnt_d = '0;
                    end else if (tcnt_q == ToutW'(TOUT - 1)) begin
                        // Give up; din keeps whatever bytes already arrived
                        state_d  = BUS_END;
                        buserr_d = 1'b1;
                        tcnt_d   = '0;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
`endif
                    end
                end

                BUS_END: state_d = BUS_IDLE;

                default: state_d = BUS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BUS_IDLE;
            a_q     <= 24'h00_0000;
            n_q     <= 3'd0;
            k_q     <= 2'd0;
            wr_q    <= 1'b0;
            wdata_q <= 32'h0000_0000;
            din_q   <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            n_q     <= n_d;
            k_q     <= k_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            din_q   <= din_d;
        end
    end

`ifdef JT900H_BUS_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_q   <= '0;
            buserr_q <= 1'b0;
        end else begin
            tcnt_q   <= tcnt_d;
            buserr_q <= buserr_d;
        end
    end

    assign buserr = buserr_q;
`else
    assign buserr = 1'b0;
`endif

endmodule

// File: tb/tb_jt900h_bus.sv
// Self-checking bench for jt900h_bus: directed cases followed by randomized
// accesses checked against a byte-level memory model.
module tb_jt900h_bus;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b0;
    logic        rd = 1'b0, wr = 1'b0;
    logic [1:0]  sz = 2'd0, addr_sel = 2'd0;
    logic [23:0] pc = '0, ea = '0, da = '0;
    logic [31:0] xsp = '0, wdata = '0;
    logic [31:0] din;
    logic        busy, buserr;
    logic [22:0] bus_addr;
    logic [15:0] bus_dout, bus_din;
    logic        bus_cs, bus_ok = 1'b0;
    logic [1:0]  bus_we;

    always #5 clk = ~clk;

    jt900h_bus dut (
        .rst      (rst),
        .clk      (clk),
        .cen      (cen),
        .rd       (rd),
        .wr       (wr),
        .sz       (sz),
        .addr_sel (addr_sel),
        .pc       (pc),
        .ea       (ea),
        .xsp      (xsp),
        .da       (da),
        .wdata    (wdata),
        .din      (din),
        .busy     (busy),
        .buserr   (buserr),
        .bus_addr (bus_addr),
        .bus_dout (bus_dout),
        .bus_din  (bus_din),
        .bus_cs   (bus_cs),
        .bus_we   (bus_we),
        .bus_ok   (bus_ok)
    );

    typedef struct packed {
        logic [22:0] addr;
        logic [1:0]  we;
        logic [15:0] dout;
    } cyc_t;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  mem  [256];   // what the bus slave holds (low 8 address bits)
    logic [7:0]  rmem [256];   // what memory should hold
    cyc_t        log_q [$];    // every acknowledged bus cycle
    logic [31:0] last_din = '0;

    assign bus_din = {mem[{bus_addr[6:0], 1'b1}], mem[{bus_addr[6:0], 1'b0}]};

    always @(posedge clk) begin
        if (!rst && cen && bus_cs && bus_ok) begin
            log_q.push_back({bus_addr, bus_we, bus_dout});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycles(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            cen    = 1'b1;
            rd     = 1'b0;
            wr     = 1'b0;
            bus_ok = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_din", din, last_din);
    endtask

    // One complete access; rnd enables random cen/bus_ok/strobe noise.
    task automatic do_access(input string tag, input bit do_rd, input bit do_wr,
                             input logic [1:0] s, input logic [1:0] as,
                             input logic [23:0] ad, input logic [31:0] wd, input bit rnd);
        int          n, base, cyc, cnt, w, idx;
        bit          is_wr, l0, l1;
        logic [31:0] exp_din;
        cyc_t        e;

        is_wr   = do_wr;
        n       = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        exp_din = '0;
        for (int i = 0; i < n; i++) exp_din[8*i +: 8] = rmem[(int'(ad) + i) & 255];
        cyc  = ((int'(ad) + n - 1) >> 1) - (int'(ad) >> 1) + 1;
        base = log_q.size();

        pc  = 24'($urandom);
        ea  = 24'($urandom);
        da  = 24'($urandom);
        xsp = $urandom;
        case (as)
            2'd0:    pc = ad;
            2'd1:    ea = ad;
            2'd2:    xsp[23:0] = ad;
            default: da = ad;
        endcase
        sz       = s;
        addr_sel = as;
        rd       = do_rd;
        wr       = do_wr;
        wdata    = wd;
        cen      = 1'b1;
        bus_ok   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);

        // Scramble request inputs to show they were latched
        rd       = 1'b0;
        wr       = 1'b0;
        wdata    = $urandom;
        sz       = 2'($urandom);
        addr_sel = 2'($urandom);
        pc       = 24'($urandom);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_cs"}, {31'd0, bus_cs}, 32'd1);

        cnt = 0;
        while (busy === 1'b1 && cnt < 400) begin
            cen    = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus_ok = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            rd     = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            wr     = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            cnt++;
        end
        rd = 1'b0;
        wr = 1'b0;
        chk({tag, "_done"}, {31'd0, busy}, 32'd0);
        if (!rnd) chk({tag, "_latency"}, cnt, cyc);
        chk({tag, "_ncyc"}, log_q.size() - base, cyc);

        for (int j = 0; j < cyc && base + j < log_q.size(); j++) begin
            e  = log_q[base + j];
            w  = (int'(ad) >> 1) + j;
            l0 = is_wr && (2*w >= int'(ad)) && (2*w < int'(ad) + n);
            l1 = is_wr && (2*w + 1 >= int'(ad)) && (2*w + 1 < int'(ad) + n);
            chk({tag, "_addr"}, {9'd0, e.addr}, {9'd0, 23'(w)});
            chk({tag, "_we"}, {30'd0, e.we}, {30'd0, l1, l0});
            if (e.we[0]) mem[(2*w) & 255]     = e.dout[7:0];
            if (e.we[1]) mem[(2*w + 1) & 255] = e.dout[15:8];
        end

        if (is_wr) begin
            for (int i = 0; i < n; i++) rmem[(int'(ad) + i) & 255] = wd[8*i +: 8];
        end else begin
            last_din = exp_din;
        end
        chk({tag, "_din"}, din, last_din);
        for (int i = -1; i <= n; i++) begin
            idx = (int'(ad) + i) & 255;
            chk({tag, "_mem"}, {24'd0, mem[idx]}, {24'd0, rmem[idx]});
        end
    endtask

    initial begin
        int          x;
        logic [23:0] ad;
        int          cnt;

        for (int i = 0; i < 256; i++) begin
            mem[i]  = 8'($urandom);
            rmem[i] = mem[i];
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_din", din, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_buserr", {31'd0, buserr}, 32'd0);
        chk("rst_cs", {31'd0, bus_cs}, 32'd0);
        chk("rst_we", {30'd0, bus_we}, 32'd0);
        chk("rst_addr", {9'd0, bus_addr}, 32'd0);
        chk("rst_dout", {16'd0, bus_dout}, 32'd0);
        rst = 1'b0;
        idle_cycles(3);

        // Byte read from odd address through ea
        mem[8'h00] = 8'h12; mem[8'h01] = 8'hAB;
        rmem[8'h00] = 8'h12; rmem[8'h01] = 8'hAB;
        do_access("byte_rd", 1'b1, 1'b0, 2'd0, 2'd1, 24'h000101, 32'h0, 1'b0);
        chk("byte_rd_val", din, 32'h0000_00AB);
        idle_cycles(2);

        // Odd long read through pc: three cycles
        mem[2] = 8'h00; mem[3] = 8'h11; mem[4] = 8'h22; mem[5] = 8'h33; mem[6] = 8'h44;
        mem[7] = 8'h55;
        for (int i = 2; i < 8; i++) rmem[i] = mem[i];
        do_access("odd_long_rd", 1'b1, 1'b0, 2'd2, 2'd0, 24'h000003, 32'h0, 1'b0);
        chk("odd_long_rd_val", din, 32'h4433_2211);
        idle_cycles(2);

        // Odd word write through xsp
        do_access("odd_word_wr", 1'b0, 1'b1, 2'd1, 2'd2, 24'h000101, 32'h0000_BEEF, 1'b0);
        chk("odd_word_wr_lo", {24'd0, mem[8'h01]}, 32'hEF);
        chk("odd_word_wr_hi", {24'd0, mem[8'h02]}, 32'hBE);
        idle_cycles(2);

        // Aligned word read: one cycle latency; sz=3 long with wrap through da
        do_access("al_word_rd", 1'b1, 1'b0, 2'd1, 2'd1, 24'h000040, 32'h0, 1'b0);
        idle_cycles(2);
        do_access("wrap_rd", 1'b1, 1'b0, 2'd3, 2'd3, 24'hFFFFFE, 32'h0, 1'b0);
        idle_cycles(2);
        do_access("both_strobes", 1'b1, 1'b1, 2'd2, 2'd1, 24'h000020, 32'hCAFE_F00D, 1'b0);
        idle_cycles(2);

        // Reset mid-access aborts and the unit accepts new work
        pc = 24'h000010; addr_sel = 2'd0; sz = 2'd2; rd = 1'b1; cen = 1'b1; bus_ok = 1'b0;
        @(negedge clk);
        rd = 1'b0;
        repeat (5) @(negedge clk);
        chk("stall_busy", {31'd0, busy}, 32'd1);
        chk("stall_cs", {31'd0, bus_cs}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_cs", {31'd0, bus_cs}, 32'd0);
        chk("abort_din", din, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_din = '0;
        do_access("post_rst_rd", 1'b1, 1'b0, 2'd1, 2'd0, 24'h000011, 32'h0, 1'b0);
        idle_cycles(2);

        // Randomized accesses with cen gaps and bus_ok stalls
        for (int t = 0; t < 40; t++) begin
            x  = $urandom_range(1, 3);
            ad = ($urandom_range(0, 7) == 0) ? 24'hFFFFFC + 24'($urandom_range(0, 3))
                                             : 24'($urandom);
            do_access("rnd", x[0], x[1], 2'($urandom), 2'($urandom), ad, $urandom, 1'b1);
            idle_cycles(2);
        end

`ifdef JT900H_BUS_TIMEOUT_EN
        // No acknowledge: abort after 15 cen cycles with buserr set
        ea = 24'h000020; addr_sel = 2'd1; sz = 2'd1; rd = 1'b1; cen = 1'b1; bus_ok = 1'b0;
        @(negedge clk);
        rd = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("tout_cycles", cnt, 15);
        chk("tout_buserr", {31'd0, buserr}, 32'd1);
        chk("tout_din", din, 32'd0);
        last_din = '0;
        idle_cycles(3);
        chk("tout_sticky", {31'd0, buserr}, 32'd1);
`else
        chk("buserr_tied", {31'd0, buserr}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jt900h_bus.md
Name: jt900h_bus

Overview:
- Memory access unit directly upstream of the register file.
- Takes byte/word/long read and write requests from the control unit, at PC, EA, XSP or DA.
- Splits each request into 16-bit little-endian external bus cycles, handling odd alignment.
- Read data is assembled into the 32-bit din word that the register file latches into md.
- busy is asserted until the whole access completes, so the microcode stalls on it.

Parameters:
- TOUT, 15: bus timeout in cen cycles; only used with the optional feature.

Ports:
- rst  in  1: asynchronous, active-high reset.
- clk  in  1: clock.
- cen  in  1: clock enable; all state advances only when cen=1.
- rd  in  1: read request strobe.
- wr  in  1: write request strobe.
- sz  in  2: access size; 0=byte, 1=word, 2=long, 3=long.
- addr_sel  in  2: address source; 0=pc, 1=ea, 2=xsp[23:0], 3=da.
- pc, ea, da  in  24: candidate addresses.
- xsp  in  32: stack pointer; bits [23:0] used.
- wdata  in  32: write data; byte 0 is at [7:0].
- din  out  32: assembled read data, zero-extended.
- busy  out  1: access in progress.
- buserr  out  1: sticky timeout flag; optional feature only, else tied 0.
- bus_addr  out  23: word address (byte address bits [23:1]).
- bus_dout  out  16: write data.
- bus_din  in  16: read data.
- bus_cs  out  1: cycle strobe.
- bus_we  out  2: write byte lanes; [0]=even byte, [1]=odd byte.
- bus_ok  in  1: cycle acknowledge.

Behaviour:
- Reset values: din=0, busy=0, buserr=0, bus_cs=0, bus_we=0, bus_addr=0, bus_dout=0, state=IDLE.
- Reset mid-access aborts immediately; no partial write is repeated.

Request acceptance:
- Accepted in IDLE when cen=1 and (rd|wr)=1.
- If rd and wr are both set, wr wins.
- Requests raised while busy=1 are ignored.
- On acceptance, latch: the byte address a from addr_sel, the byte count n=1/2/4, the direction, and wdata.
- Clear din when a read is accepted. Set busy=1 on the same edge.

States:
- IDLE: waits for a request.
- CYC:
  - bus_cs=1, bus_addr=a[23:1].
  - Lane mask: if a[0]=1, only the odd lane. If a[0]=0 and n>=2, both lanes. If a[0]=0 and n=1, only the even lane.
  - Writes: bus_we equals the lane mask, and the bytes go out on their lanes.
  - Hold all outputs until bus_ok=1 is sampled with cen=1.
  - Then store the read bytes at din[8*k +: 8] (k = byte index into the request), advance a by the lanes consumed, decrement n and k accordingly.
  - If n reaches 0, go to END; otherwise stay in CYC with the updated address, without deasserting bus_cs.
- END: bus_cs=0, bus_we=0, busy=0. Return to IDLE on the next cen cycle.

Cycle count and latency:
- Byte: 1 bus cycle.
- Aligned word: 1. Odd word: 2.
- Aligned long: 2. Odd long: 3.
- With bus_ok already high, aligned word read requested at edge N: bus_cs high N..N+1, din valid and busy low after edge N+1.

Boundary rules:
- Address increments wrap modulo 2^24 (0xFFFFFF+1 -> 0x000000).
- sz=3 is treated as long.
- bus_ok while IDLE is ignored.
- cen=0 freezes every state and output.

Optional Feature:
- Macro: JT900H_BUS_TIMEOUT_EN.
- When defined:
  - A 4-bit-wide counter (sized from TOUT) counts cen cycles while in CYC without bus_ok.
  - On reaching TOUT, abort to END and set buserr=1. din keeps the bytes gathered so far.
  - buserr is cleared only by reset.
- When undefined: no counter, buserr=0, CYC waits forever.

Decomposition:
- Shared package 900h_param.vh gains:
  - size codes BYTE_SZ/WORD_SZ/LONG_SZ;
  - address selects PC_ASEL/EA_ASEL/XSP_ASEL/DA_ASEL;
  - state encodings BUS_IDLE/BUS_CYC/BUS_END.
- No sub-module. Lane/byte steering is combinational logic inside the block.

Test Plan:
- Byte read, addr_sel=ea=0x000101, bus_din=0xAB12 with immediate ok -> bus_addr=0x000080, one cycle, din=0x000000AB.
- Long read at pc=0x000003, data 0x1100/0x3322/0x5544 -> three cycles at word addresses 1,2,3, din=0x44332211.
- Word write 0xBEEF at xsp=0x000101 -> cycle 1: we=10, dout[15:8]=0xEF; cycle 2: we=01, dout[7:0]=0xBE.
- Long read at da=0xFFFFFE -> second cycle at bus_addr=0x000000 (wrap).
- bus_ok held low 5 cycles mid-long-read, then rst pulsed -> busy=0, bus_cs=0, din=0; a new request is accepted after reset.
- With JT900H_BUS_TIMEOUT_EN and TOUT=15, bus_ok never asserted -> after 15 cen cycles buserr=1, busy=0.
